// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - fetch PC, in-order imem requests, prefetch queue feeding decode.
// Optional same-cycle response-to-decode bypass is enabled by defining IF_RESP_BYPASS_EN.
package fetch_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc4;
    logic [63:0] pc;
  } IF_regs_t;
endpackage

module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic        if_valid,
  output IF_regs_t    if_regs,
  input  logic        id_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d, outstanding_q, outstanding_d, drop_q, drop_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] pf_head_q, pf_head_d, pf_tail_q, pf_tail_d;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];
  logic [63:0]   pc_q   [DEPTH];
  logic [63:0]   pc_d   [DEPTH];
  logic [63:0]   pf_q   [DEPTH];
  logic [63:0]   pf_d   [DEPTH];

  logic        req_fire, resp_live, bypass, deq, pop, enq;
  logic [63:0] head_pc;
  logic [31:0] head_inst;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    imem_req_valid = !reset && !flush &&
                     (({1'b0, count_q} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_live      = imem_resp_valid && (drop_q == '0) && !flush && !reset;
`ifdef IF_RESP_BYPASS_EN
    bypass         = resp_live && (count_q == '0);
`else
    bypass         = 1'b0;
`endif
    if_valid       = !reset && !flush && ((count_q != '0) || bypass);
    head_inst      = bypass ? imem_resp_inst : inst_q[head_q];
    head_pc        = bypass ? pf_q[pf_head_q] : pc_q[head_q];
    if_regs        = '0;
    if (if_valid) begin
      if_regs.inst = head_inst;
      if_regs.pc   = head_pc;
      if_regs.pc4  = head_pc + 64'd4;
    end
    deq = if_valid && id_ready;
    // A bypassed response that decode takes this cycle never occupies a slot.
    pop = deq && !bypass;
    enq = resp_live && !(bypass && id_ready);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    pf_head_d     = pf_head_q;
    pf_tail_d     = pf_tail_q;
    drop_d        = drop_q;
    inst_d        = inst_q;
    pc_d          = pc_q;
    pf_d          = pf_q;
    if (pop) head_d = head_q + AW'(1);
    if (enq) begin
      inst_d[tail_q] = imem_resp_inst;
      pc_d[tail_q]   = pf_q[pf_head_q];
      tail_d         = tail_q + AW'(1);
    end
    count_d = count_q + CW'(enq) - CW'(pop);
    if (req_fire) begin
      pf_d[pf_tail_q] = fetch_pc_q;
      pf_tail_d       = pf_tail_q + AW'(1);
      fetch_pc_d      = fetch_pc_q + 64'd4;
    end
    if (imem_resp_valid) pf_head_d = pf_head_q + AW'(1);
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
    if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    // Stale responses are already part of outstanding, so every in-flight one is dropped.
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      drop_d     = outstanding_q - CW'(imem_resp_valid);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      pf_head_q     <= '0;
      pf_tail_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
        pf_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      pf_head_q     <= pf_head_d;
      pf_tail_q     <= pf_tail_d;
      inst_q        <= inst_d;
      pc_q          <= pc_d;
      pf_q          <= pf_d;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed and random stimulus against a queue-level fetch model.
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
`ifdef IF_RESP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, flush, imem_req_valid, imem_req_ready, imem_resp_valid, if_valid, id_ready;
  logic [63:0] redirect_pc, imem_req_addr;
  logic [31:0] imem_resp_inst;
  IF_regs_t    if_regs;

  always #5 clock = ~clock;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clock(clock), .reset(reset), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_inst(imem_resp_inst), .if_valid(if_valid), .if_regs(if_regs),
    .id_ready(id_ready)
  );

  typedef struct { logic [63:0] pc; bit stale; int due; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;

  req_t        inflight[$];
  ent_t        mq[$];
  logic [63:0] m_pc;
  int          cyc, n_checks, n_fail;
  int          lat_min, lat_max, p_ready, p_id, p_flush, ready_force;
  bit          force_flush, force_reset;
  logic [63:0] force_pc;
  bit          o_valid, o_fire, o_hs, o_resp;
  logic [63:0] o_pc, o_addr;

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[33:2] ^ 32'h5A3C_96E1 ^ pc[63:32];
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit          exp_req, exp_iv, byp, resp, deq, any_stale;
    logic [63:0] hpc;
    logic [31:0] hinst;
    req_t        r;
    reset = force_reset;
    if (ready_force >= 0) imem_req_ready = ready_force[0];
    else imem_req_ready = ($urandom_range(99) < p_ready);
    id_ready = ($urandom_range(99) < p_id);
    flush = !force_reset && (force_flush || ($urandom_range(999) < p_flush));
    if (force_flush) redirect_pc = force_pc;
    else if ($urandom_range(7) == 0) redirect_pc = {60'hFFFF_FFFF_FFFF_FFF, 4'($urandom)};
    else redirect_pc = {$urandom, $urandom};
    resp = !force_reset && (inflight.size() > 0) && (inflight[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_inst  = resp ? inst_of(inflight[0].pc) : $urandom;
    any_stale = 1'b0;
    foreach (inflight[i]) if (inflight[i].stale) any_stale = 1'b1;

    @(negedge clock);
    exp_req = !reset && !flush && (mq.size() + inflight.size() < DEPTH);
    byp     = BYP && resp && !flush && !reset && (mq.size() == 0) && !any_stale;
    exp_iv  = !reset && !flush && ((mq.size() > 0) || byp);
    hpc = 64'h0;
    hinst = 32'h0;
    if (mq.size() > 0) begin
      hpc = mq[0].pc;
      hinst = mq[0].inst;
    end else if (byp) begin
      hpc = inflight[0].pc;
      hinst = inst_of(inflight[0].pc);
    end
    chk("req_valid", 160'(imem_req_valid), 160'(exp_req));
    if (exp_req) chk("req_addr", 160'(imem_req_addr), 160'(m_pc));
    chk("if_valid", 160'(if_valid), 160'(exp_iv));
    chk("if_regs", if_regs, exp_iv ? {hinst, hpc + 64'd4, hpc} : 160'd0);
    o_valid = if_valid;
    o_pc    = if_regs.pc;
    o_fire  = if_valid && id_ready;
    o_hs    = imem_req_valid && imem_req_ready;
    o_addr  = imem_req_addr;
    o_resp  = resp;
    deq     = exp_iv && id_ready;

    @(posedge clock);
    if (reset) begin
      mq.delete();
      inflight.delete();
      m_pc = 64'h0;
    end else begin
      if (deq && !byp) void'(mq.pop_front());
      if (resp) begin
        r = inflight.pop_front();
        if (!r.stale && !flush && !(byp && id_ready)) mq.push_back('{r.pc, inst_of(r.pc)});
      end
      if (exp_req && imem_req_ready) begin
        inflight.push_back('{m_pc, 1'b0, cyc + int'($urandom_range(lat_max, lat_min))});
        m_pc = m_pc + 64'd4;
      end
      if (flush) begin
        mq.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_pc = {redirect_pc[63:2], 2'b00};
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    force_reset = 1'b1;
    cycle();
    cycle();
    force_reset = 1'b0;
  endtask

  initial begin
    logic [63:0] pcs[$];
    bit          vb[20], rb[20];
    bit          found, got;
    int          k, bubbles, accepted, stale_seen;
    logic [63:0] first_pc, prev_pc, addr;
    bit          pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n_checks = 0; n_fail = 0; cyc = 0; m_pc = 64'h0;
    lat_min = 1; lat_max = 1; p_ready = 100; p_id = 100; p_flush = 0; ready_force = -1;
    force_flush = 1'b0; force_pc = 64'h0; force_reset = 1'b1;
    reset = 1'b1; flush = 1'b0; redirect_pc = 64'h0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_inst = 32'h0; id_ready = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    // streaming with single-cycle memory
    pcs.delete();
    for (int i = 0; i < 20; i++) begin
      cycle();
      vb[i] = o_valid;
      rb[i] = o_resp;
      if (o_fire) pcs.push_back(o_pc);
    end
    found = 1'b0; k = 0;
    for (int i = 0; i < 20; i++) if (rb[i] && !found) begin found = 1'b1; k = i; end
    chk("resp_seen", 160'(found), 160'(1));
    chk("valid_on_resp_cycle", 160'(vb[k]), 160'(BYP));
    chk("valid_after_resp", 160'(vb[k+1]), 160'(1));
    bubbles = 0;
    for (int i = k + 2; i < 20; i++) if (!vb[i]) bubbles++;
    chk("no_bubbles", 160'(bubbles), 160'(0));
    chk("stream_len", 160'(pcs.size() >= 3), 160'(1));
    chk("stream_pc0", 160'(pcs[0]), 160'(64'h0));
    chk("stream_pc1", 160'(pcs[1]), 160'(64'h4));
    chk("stream_pc2", 160'(pcs[2]), 160'(64'h8));

    // back-pressure fills exactly DEPTH entries
    do_reset();
    p_id = 0; accepted = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (o_hs) accepted++;
    end
    chk("accepted_when_stalled", 160'(accepted), 160'(DEPTH));
    chk("req_blocked", 160'(o_hs), 160'(0));
    p_id = 100; pcs.delete(); got = 1'b0; addr = 64'h0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (o_fire) pcs.push_back(o_pc);
      if (o_hs && !got) begin got = 1'b1; addr = o_addr; end
    end
    chk("drain_len", 160'(pcs.size() >= 4), 160'(1));
    chk("drain_pc0", 160'(pcs[0]), 160'(64'h0));
    chk("drain_pc1", 160'(pcs[1]), 160'(64'h4));
    chk("drain_pc2", 160'(pcs[2]), 160'(64'h8));
    chk("drain_pc3", 160'(pcs[3]), 160'(64'hC));
    chk("resume_addr", 160'(addr), 160'(64'h10));

    // flush with two requests in flight, latency 3
    do_reset();
    lat_min = 3; lat_max = 3;
    cycle();
    cycle();
    p_ready = 0; force_flush = 1'b1; force_pc = 64'h1000;
    cycle();
    force_flush = 1'b0; p_ready = 100;
    cycle();
    chk("post_flush_hs", 160'(o_hs), 160'(1));
    chk("post_flush_addr", 160'(o_addr), 160'(64'h1000));
    got = 1'b0; first_pc = 64'h0; stale_seen = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (o_fire && !got) begin got = 1'b1; first_pc = o_pc; end
      if (o_fire && o_pc < 64'h1000) stale_seen++;
    end
    chk("flush_first_pc", 160'(first_pc), 160'(64'h1000));
    chk("flush_no_stale", 160'(stale_seen), 160'(0));

    // flush to an unaligned target while a response lands
    do_reset();
    lat_min = 1; lat_max = 1;
    cycle();
    p_ready = 0; force_flush = 1'b1; force_pc = 64'h1003;
    cycle();
    force_flush = 1'b0; p_ready = 100;
    got = 1'b0; first_pc = 64'h0;
    cycle();
    chk("align_hs", 160'(o_hs), 160'(1));
    chk("align_addr", 160'(o_addr), 160'(64'h1000));
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (o_fire && !got) begin got = 1'b1; first_pc = o_pc; end
    end
    chk("align_first_pc", 160'(first_pc), 160'(64'h1000));

    // request ready toggling 1,0,0,1
    do_reset();
    lat_min = 2; lat_max = 2; p_id = 60; got = 1'b0; prev_pc = 64'h0;
    for (int i = 0; i < 40; i++) begin
      ready_force = int'(pat[i % 4]);
      cycle();
      if (o_fire) begin
        if (got) chk("pc_order", 160'(o_pc), 160'(prev_pc + 64'd4));
        prev_pc = o_pc;
        got = 1'b1;
      end
    end
    ready_force = -1;

    // random traffic with redirects and a reset mid-stream
    lat_min = 1; lat_max = 4; p_ready = 70; p_id = 70; p_flush = 30;
    for (int i = 0; i < 3000; i++) begin
      force_reset = (i == 1500) || (i == 1501);
      cycle();
    end
    force_reset = 1'b0;
    p_flush = 0;
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
